// File: rtl/switch_debounce_pulse.sv
// switch_debounce_pulse: four-channel push-button conditioner.
// Each raw switch passes through a two-flop synchroniser and a per-channel
// stability counter. It is presented as a clean level plus one-cycle
// press and release pulses.
// Optional feature macro: DEBOUNCE_REPEAT_EN. When it is defined, a held
// switch also produces auto-repeat press pulses.
module switch_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Switches,
    output logic [3:0] o_Switches,
    output logic [3:0] o_Press,
    output logic [3:0] o_Release,
    output logic       o_Any
);

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter values outside the legal range at elaboration.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("switch_debounce_pulse: illegal parameter value");
    end

    logic [3:0]       s1_q;
    logic [3:0]       s2_q;
    logic [3:0]       stable_q;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [3:0]       press_q;
    logic [3:0]       press_d;
    logic [3:0]       release_q;
    logic [3:0]       release_d;
    logic [3:0]       accept;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q [N_CH];
    logic [RPT_W-1:0] rpt_d [N_CH];
    logic [3:0]       first_done_q;
    logic [3:0]       first_done_d;
    logic [3:0]       rpt_fire;
`endif

    // Synchroniser for the asynchronous switch levels.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
        end else begin
            s1_q <= i_Switches;
            s2_q <= s1_q;
        end
    end

    // Per-channel debounce next-state: count the cycles a differing level holds.
    always_comb begin
        stable_d  = stable_q;
        press_d   = 4'b0000;
        release_d = 4'b0000;
        accept    = 4'b0000;
        for (int n = 0; n < N_CH; n++) begin
            cnt_d[n] = cnt_q[n];
            if (s2_q[n] == stable_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_LAST) begin
                accept[n]    = 1'b1;
                stable_d[n]  = s2_q[n];
                cnt_d[n]     = '0;
                press_d[n]   = s2_q[n];
                release_d[n] = ~s2_q[n];
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
`ifdef DEBOUNCE_REPEAT_EN
        rpt_fire     = 4'b0000;
        first_done_d = first_done_q;
        for (int n = 0; n < N_CH; n++) begin
            rpt_d[n] = rpt_q[n];
            if (accept[n]) begin
                // Either edge of an accepted transition restarts the repeat schedule.
                rpt_d[n]        = '0;
                first_done_d[n] = 1'b0;
            end else if (stable_q[n]) begin
                if (rpt_q[n] == (first_done_q[n] ? PERIOD_LAST : DELAY_LAST)) begin
                    rpt_fire[n]     = 1'b1;
                    rpt_d[n]        = '0;
                    first_done_d[n] = 1'b1;
                end else begin
                    rpt_d[n] = rpt_q[n] + RPT_W'(1);
                end
            end
        end
        press_d = press_d | rpt_fire;
`endif
    end

    // Debounce state and registered pulse outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            stable_q  <= 4'b0000;
            press_q   <= 4'b0000;
            release_q <= 4'b0000;
            for (int n = 0; n < N_CH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int n = 0; n < N_CH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    // Auto-repeat counters and first-repeat flags.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            first_done_q <= 4'b0000;
            for (int n = 0; n < N_CH; n++) begin
                rpt_q[n] <= '0;
            end
        end else begin
            first_done_q <= first_done_d;
            for (int n = 0; n < N_CH; n++) begin
                rpt_q[n] <= rpt_d[n];
            end
        end
    end
`endif

    assign o_Switches = stable_q;
    assign o_Press    = press_q;
    assign o_Release  = release_q;
    assign o_Any      = |press_q;

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// Bench for switch_debounce_pulse: vector table, hand sequences, and a
// randomized run checked against a history-based reference model.
module tb_switch_debounce_pulse;

    localparam int unsigned DB  = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 5;

    bit         clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic [3:0] i_Switches = 4'b0000;
    logic [3:0] o_Switches;
    logic [3:0] o_Press;
    logic [3:0] o_Release;
    logic       o_Any;

    int n_checks = 0;
    int n_errors = 0;

    switch_debounce_pulse #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_Clk     (clk),
        .i_Reset   (i_Reset),
        .i_Switches(i_Switches),
        .o_Switches(o_Switches),
        .o_Press   (o_Press),
        .o_Release (o_Release),
        .o_Any     (o_Any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // One clock edge: inputs change at the falling edge, outputs are read 1 after the rising edge.
    task automatic drive(input logic rst, input logic [3:0] sw);
        @(negedge clk);
        i_Reset    = rst;
        i_Switches = sw;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a level is accepted once the last DB synchronised samples
    // taken since the previous acceptance (or reset) all differ from it.
    logic [3:0] pipe_q [$];
    logic [3:0] hist_q [$];
    int         valid_from [4];
    longint     next_rpt [4];
    longint     edge_no = 0;
    bit         m_live = 1'b0;
    logic [3:0] m_sw, m_pr, m_rl;
    bit         rpt_en;

    initial begin
`ifdef DEBOUNCE_REPEAT_EN
        rpt_en = 1'b1;
`else
        rpt_en = 1'b0;
`endif
    end

    always @(posedge clk) begin
        logic [3:0] d;
        bit ok;
        edge_no++;
        if (i_Reset) begin
            m_live = 1'b1;
            pipe_q.delete();
            pipe_q.push_back(4'b0000);
            pipe_q.push_back(4'b0000);
            m_sw = 4'b0000;
            m_pr = 4'b0000;
            m_rl = 4'b0000;
            for (int n = 0; n < 4; n++) begin
                valid_from[n] = hist_q.size();
                next_rpt[n]   = -1;
            end
        end else if (m_live) begin
            m_pr = 4'b0000;
            m_rl = 4'b0000;
            d = pipe_q.pop_front();
            pipe_q.push_back(i_Switches);
            hist_q.push_back(d);
            for (int n = 0; n < 4; n++) begin
                ok = (hist_q.size() - valid_from[n]) >= int'(DB);
                for (int k = 0; k < int'(DB); k++) begin
                    if (ok && hist_q[hist_q.size() - 1 - k][n] == m_sw[n]) ok = 1'b0;
                end
                if (ok) begin
                    m_sw[n]       = d[n];
                    valid_from[n] = hist_q.size();
                    if (d[n]) begin
                        m_pr[n]     = 1'b1;
                        next_rpt[n] = edge_no + RD;
                    end else begin
                        m_rl[n]     = 1'b1;
                        next_rpt[n] = -1;
                    end
                end else if (rpt_en && m_sw[n] && edge_no == next_rpt[n]) begin
                    m_pr[n]     = 1'b1;
                    next_rpt[n] = edge_no + RP;
                end
            end
        end
        if (m_live) begin
            #1;
            chk("model_level",   o_Switches, m_sw);
            chk("model_press",   o_Press,    m_pr);
            chk("model_release", o_Release,  m_rl);
            chk("model_any",     {3'b000, o_Any}, {3'b000, |m_pr});
        end
    end

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic [3:0] esw;
        logic [3:0] epr;
        logic [3:0] erl;
    } vec_t;

    vec_t vecs [$];

    function automatic void add_vec(logic rst, logic [3:0] sw, logic [3:0] esw,
                                    logic [3:0] epr, logic [3:0] erl);
        vec_t v;
        v.rst = rst; v.sw = sw; v.esw = esw; v.epr = epr; v.erl = erl;
        vecs.push_back(v);
    endfunction

    initial begin
        int presses;
        logic [3:0] sw_r;

        // Reset, clean press on channel 0, then clean release.
        add_vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 1; k <= 7; k++)
            add_vec(1'b0, 4'b0001, (k >= 6) ? 4'b0001 : 4'b0000,
                    (k == 6) ? 4'b0001 : 4'b0000, 4'b0000);
        for (int k = 1; k <= 7; k++)
            add_vec(1'b0, 4'b0000, (k >= 6) ? 4'b0000 : 4'b0001,
                    4'b0000, (k == 6) ? 4'b0001 : 4'b0000);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].sw);
            chk("tbl_level",   o_Switches, vecs[i].esw);
            chk("tbl_press",   o_Press,    vecs[i].epr);
            chk("tbl_release", o_Release,  vecs[i].erl);
            chk("tbl_any",     {3'b000, o_Any}, {3'b000, |vecs[i].epr});
        end

        // Bounce on channel 1: high 2, low 1, then steady high.
        presses = 0;
        for (int e = 1; e <= 10; e++) begin
            drive(1'b0, (e == 3) ? 4'b0000 : 4'b0010);
            if (o_Press[1]) presses++;
            chk("bounce_press", o_Press, (e == 9) ? 4'b0010 : 4'b0000);
        end
        chk("bounce_count", 4'(presses), 4'd1);
        for (int e = 1; e <= 8; e++) drive(1'b0, 4'b0000);
        chk("bounce_released", o_Switches, 4'b0000);

        // Simultaneous press on channels 2 and 3, then release.
        for (int e = 1; e <= 7; e++) begin
            drive(1'b0, 4'b1100);
            chk("simul_press", o_Press, (e == 6) ? 4'b1100 : 4'b0000);
            chk("simul_any", {3'b000, o_Any}, (e == 6) ? 4'b0001 : 4'b0000);
        end
        for (int e = 1; e <= 7; e++) begin
            drive(1'b0, 4'b0000);
            chk("simul_release", o_Release, (e == 6) ? 4'b1100 : 4'b0000);
        end

        // Reset two edges into the debounce window with the switch still held.
        drive(1'b0, 4'b0001);
        drive(1'b0, 4'b0001);
        for (int e = 1; e <= 2; e++) begin
            drive(1'b1, 4'b0001);
            chk("rst_level",   o_Switches, 4'b0000);
            chk("rst_press",   o_Press,    4'b0000);
            chk("rst_release", o_Release,  4'b0000);
        end
        for (int e = 1; e <= 7; e++) begin
            drive(1'b0, 4'b0001);
            chk("rst_after_press", o_Press, (e == 6) ? 4'b0001 : 4'b0000);
            chk("rst_after_level", o_Switches, (e >= 6) ? 4'b0001 : 4'b0000);
        end
        for (int e = 1; e <= 7; e++) drive(1'b0, 4'b0000);
        chk("rst_final_level", o_Switches, 4'b0000);

`ifdef DEBOUNCE_REPEAT_EN
        // Held switch: press at edge 6, repeats at +10, +15, +20, released before the next.
        for (int e = 1; e <= 40; e++) begin
            drive(1'b0, (e < 24) ? 4'b0001 : 4'b0000);
            chk("rpt_press", o_Press,
                (e == 6 || e == 16 || e == 21 || e == 26) ? 4'b0001 : 4'b0000);
            chk("rpt_release", o_Release, (e == 29) ? 4'b0001 : 4'b0000);
        end
`endif

        // Randomized run with occasional resets; the reference model checks every edge.
        sw_r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 4; n++)
                if ($urandom_range(0, 9) == 0) sw_r[n] = ~sw_r[n];
            drive(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, sw_r);
        end
        for (int e = 0; e < 12; e++) drive(1'b0, 4'b0000);

        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
